// File: rtl/branch_target_sched_pkg.sv
// Shared definitions for the branch/jump target scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package branch_target_sched_pkg;

    // Source tag carried with every target; also the round-robin pointer encoding.
    localparam logic SRC_BR = 1'b0;
    localparam logic SRC_J  = 1'b1;

    // Jump instruction index width fixed by the MIPS J-format.
    localparam int MIPS_JIDX_W = 26;

    // One entry of the shift stage: operand already shifted left by 2,
    // base is the requester's PC+4.
    typedef struct packed {
        logic        valid;
        logic        src;
        logic [31:0] base;
        logic [31:0] shift;
    } pipe_entry_t;

endpackage

// File: rtl/branch_target_sched_arbiter.sv
// Two-requester arbiter (branch vs jump) with round-robin or fixed priority.
// Latency: grants are combinational from req/en; pointer updates on the granting edge.
// Backpressure: en low suppresses both grants; pointer holds.
//
// Ports:
//   Clk, Rst        clock, async active-high reset
//   en              grant allowed this cycle (pipeline can accept, no flush)
//   br_req, j_req   requests
//   br_gnt, j_gnt   one-hot-or-zero grants
module tgt_rr_arbiter
    import branch_target_sched_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic Clk,
    input  logic Rst,
    input  logic en,
    input  logic br_req,
    input  logic j_req,
    output logic br_gnt,
    output logic j_gnt
);

    // Source of the most recent grant; reset to jump so branch wins the first tie.
    logic last_src;
    logic pick_j;

    always_comb begin
        pick_j = 1'b0;
        if (br_req && j_req) begin
            // On a tie, round-robin favours whoever did not win last time.
            pick_j = RR_EN ? (last_src == SRC_BR) : 1'b0;
        end else begin
            pick_j = j_req;
        end
    end

    assign br_gnt = en & br_req & ~pick_j;
    assign j_gnt  = en & j_req  &  pick_j;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            last_src <= SRC_J;
        end else if (br_gnt || j_gnt) begin
            last_src <= j_gnt ? SRC_J : SRC_BR;
        end
    end

endmodule

// File: rtl/branch_target_sched.sv
// Schedules branch and jump target formation through one shared shift-by-2 stage.
// Latency: 2 cycles from grant to tgt_valid; 1 target/cycle with tgt_ready high.
// Backpressure: tgt_ready low holds S2, S1 holds when full, grants drop to 0.
//
// Ports:
//   Clk, Rst                      clock, async active-high reset
//   br_req/br_imm/br_pc4/br_gnt   branch requester (imm already sign-extended)
//   j_req/j_index/j_pc4/j_gnt     jump requester
//   flush                         drop all in-flight work at the next edge
//   tgt_valid/tgt_ready           output handshake
//   tgt_addr/tgt_src              target and its source (0 branch, 1 jump)
//   busy                          either stage holds a valid entry
module branch_target_sched
    import branch_target_sched_pkg::*;
#(
    parameter bit RR_EN  = 1'b1,
    parameter int JIDX_W = MIPS_JIDX_W
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              br_req,
    input  logic [31:0]       br_imm,
    input  logic [31:0]       br_pc4,
    output logic              br_gnt,
    input  logic              j_req,
    input  logic [JIDX_W-1:0] j_index,
    input  logic [31:0]       j_pc4,
    output logic              j_gnt,
    input  logic              flush,
    output logic              tgt_valid,
    input  logic              tgt_ready,
    output logic [31:0]       tgt_addr,
    output logic              tgt_src,
    output logic              busy
);

    if (JIDX_W != MIPS_JIDX_W) begin : g_jidx_chk
        $error("branch_target_sched: JIDX_W must be 26");
    end

    pipe_entry_t s1_q;
    pipe_entry_t s1_d;
    logic        s2_valid;
    logic        s2_adv;
    logic        s1_adv;
    logic        gnt_en;
    logic [31:0] operand;
    logic [31:0] s2_addr_d;

    assign s2_adv = ~s2_valid | tgt_ready;
    assign s1_adv = ~s1_q.valid | s2_adv;
    assign gnt_en = s1_adv & ~flush;

    tgt_rr_arbiter #(
        .RR_EN (RR_EN)
    ) u_arb (
        .Clk    (Clk),
        .Rst    (Rst),
        .en     (gnt_en),
        .br_req (br_req),
        .j_req  (j_req),
        .br_gnt (br_gnt),
        .j_gnt  (j_gnt)
    );

    // Shared shifter input: jump index is zero-extended before the shift.
    always_comb begin
        operand     = j_gnt ? {{(32-JIDX_W){1'b0}}, j_index} : br_imm;
        s1_d        = '0;
        s1_d.valid  = br_gnt | j_gnt;
        s1_d.src    = j_gnt ? SRC_J : SRC_BR;
        s1_d.base   = j_gnt ? j_pc4 : br_pc4;
        s1_d.shift  = operand << 2;
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            s1_q <= '0;
        end else if (flush) begin
            s1_q.valid <= 1'b0;
        end else if (s1_adv) begin
            // No grant simply leaves an empty slot; data fields follow s1_d.
            s1_q <= s1_d;
        end
    end

    // Branch adds with silent 32-bit wrap; jump keeps the PC region bits.
    always_comb begin
        if (s1_q.src == SRC_J) begin
            s2_addr_d = {s1_q.base[31:28], s1_q.shift[27:0]};
        end else begin
            s2_addr_d = s1_q.base + s1_q.shift;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            s2_valid <= 1'b0;
            tgt_addr <= '0;
            tgt_src  <= SRC_BR;
        end else if (flush) begin
            s2_valid <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_q.valid;
            // Output data is left as-is when a bubble moves in.
            if (s1_q.valid) begin
                tgt_addr <= s2_addr_d;
                tgt_src  <= s1_q.src;
            end
        end
    end

    assign tgt_valid = s2_valid;
    assign busy      = s1_q.valid | s2_valid;

endmodule

// File: doc/branch_target_sched.md
Name: branch_target_sched

Overview:
- Scheduler for the shared shift-left-by-2 target datapath in the MIPS core.
- Two requesters need the single shift-by-2 register stage and follow-on target formation:
  - the branch unit, whose target is PC+4 plus the sign-extended immediate shifted left by 2;
  - the jump unit, whose target is PC+4[31:28], then the 26-bit index, then 2'b00.
- The block arbitrates between them (round-robin), runs a 2-stage pipeline (shift register stage S1, target register stage S2), and presents one tagged target with a valid/ready handshake and flush support.

Parameters:
- RR_EN, 1: 1 = round-robin when both requesters are active; 0 = fixed priority, branch always wins.
- JIDX_W, 26: jump index width. Must be 26 for MIPS; any other value is a config error caught by an elaboration assert.

Ports:
- Clk  input  1  clock, rising edge.
- Rst  input  1  asynchronous, active-high reset.
- br_req  input  1  branch target request; held with data until granted.
- br_imm  input  32  sign-extended branch immediate.
- br_pc4  input  32  PC+4 of the branch.
- br_gnt  output  1  branch request accepted this cycle (combinational).
- j_req  input  1  jump target request; held with data until granted.
- j_index  input  26  jump instruction index.
- j_pc4  input  32  PC+4 of the jump.
- j_gnt  output  1  jump request accepted this cycle (combinational).
- flush  input  1  kill all in-flight target work.
- tgt_valid  output  1  tgt_addr/tgt_src valid.
- tgt_ready  input  1  consumer accepts the target.
- tgt_addr  output  32  computed target address.
- tgt_src  output  1  0 = branch, 1 = jump.
- busy  output  1  S1 or S2 holds a valid entry.

Behaviour:
- Reset (async, Rst=1):
  - s1_valid=0, s2_valid=0, tgt_valid=0, tgt_addr=0, tgt_src=0, busy=0.
  - Round-robin pointer last_src=1, so branch wins the first tie.
- Transfer rules:
  - A request transfers when req & gnt in the same cycle.
  - Gnt is never asserted without req.
  - At most one gnt per cycle.
- Stage advance:
  - s2_adv = !s2_valid | tgt_ready.
  - s1_adv = !s1_valid | s2_adv.
  - A grant is possible only when s1_adv=1 and flush=0.
- Arbitration:
  - Only one requester active: it wins.
  - Both active with RR_EN=1: grant the source != last_src.
  - Both active with RR_EN=0: grant branch.
  - last_src updates only on an actual grant.
- S1 capture on grant, modelled on the shared shifter:
  - s1_shift = operand << 2, where operand = br_imm for a branch or zero-extended j_index for a jump.
  - s1_base = br_pc4 or j_pc4.
  - s1_src = grant source.
  - s1_valid = 1.
- S1 when s1_adv=1 and no grant: s1_valid=0.
- S2 capture when s2_adv=1:
  - s2_valid = s1_valid.
  - If s1_valid: branch tgt_addr = s1_base + s1_shift, wrapping mod 2^32 with no overflow flag; jump tgt_addr = {s1_base[31:28], s1_shift[27:0]}. tgt_src = s1_src.
- Stall: s2_valid=1 and tgt_ready=0:
  - S2 holds its data stable.
  - S1 holds if valid.
  - Both gnts are 0 if S1 is full.
- Latency:
  - Grant in cycle N gives tgt_valid in cycle N+2 with no backpressure.
  - Throughput is 1 target/cycle with tgt_ready held high.
- Flush:
  - At the next edge, s1_valid=0 and s2_valid=0.
  - Gnts are forced to 0 in the flush cycle.
  - last_src is unchanged.
  - A target presented in the flush cycle is dropped even if tgt_ready=1; the consumer ignores it.
- busy = s1_valid | s2_valid.
- tgt_addr/tgt_src are don't-care when tgt_valid=0; they keep their last value and are not cleared.
- Reset mid-operation discards both stages immediately; outputs go to their reset values asynchronously.

Decomposition:
- Shared package holds:
  - SRC_BR=1'b0, SRC_J=1'b1;
  - MIPS_JIDX_W=26;
  - the pipeline entry typedef {valid, src, base[31:0], shift[31:0]}.
- One natural sub-module: tgt_rr_arbiter, a 2-requester round-robin arbiter with enable, RR_EN mode and the last_src pointer.
- The shift and add stages stay inline.

Test Plan:
- Branch alone: br_pc4=0x0040_0010, br_imm=0xFFFF_FFFC, tgt_ready=1 -> br_gnt in cycle 0; tgt_valid in cycle 2 with tgt_addr=0x0040_0000, tgt_src=0.
- Jump alone: j_pc4=0x9000_0004, j_index=0x000_0040 -> tgt_addr=0x9000_0100, tgt_src=1, 2 cycles after j_gnt.
- Both requests held for 4 cycles, RR_EN=1 -> grants alternate br, j, br, j. With RR_EN=0, br is granted 4 times and j is never granted.
- Backpressure: tgt_ready=0 for 3 cycles with continuous br_req -> S2 and S1 fill; gnts go to 0; tgt_addr stays stable. When tgt_ready=1, targets emerge in grant order with none lost or duplicated.
- Flush with both stages full and a pending j_req -> no gnt that cycle; tgt_valid=0 and busy=0 next cycle; j_gnt the cycle after.
- Wrap and reset: br_pc4=0xFFFF_FFF0, br_imm=0x0000_0008 -> tgt_addr=0x0000_0010. Rst pulsed mid-pipeline -> tgt_valid=0 and busy=0 immediately, and the next tie grants branch first.
